mfp_ahb_sevenseg_multi: RTL and testbench
=========================================

// Module: mfp_ahb_sevenseg_multi
// PURPOSE
//  AHB-Lite slave driving an N-digit multiplexed 7-segment display; parametrised successor of the fixed 8-digit unit.
//  Adds per-digit hex/raw mode, per-digit blink, global PWM brightness, inter-slot ghost blanking and register readback.
//  Sits on the MFP AHB bus decoder (HSEL from decoder), drives board anode/cathode pins directly.
// PARAMETERS
//  NUM_DIGITS   8           digits scanned, 1..16
//  REFRESH_DIV  25000       HCLK cycles per digit slot (>=4)
//  BLINK_DIV    12500000    HCLK cycles per blink half-period (>=2)
//  PWM_BITS     4           brightness counter width
// PORTS
//  HCLK       in   1           bus/system clock
//  HRESET     in   1           synchronous reset, active-high
//  HADDR      in   8           byte address, [1:0] ignored
//  HWDATA     in   32          write data (data phase)
//  HWRITE     in   1           1 = write
//  HSEL       in   1           slave select
//  HTRANS     in   2           transfer type; HTRANS[1]=1 is a valid transfer
//  HRDATA     out  32          read data (data phase)
//  DISPENOUT  out  NUM_DIGITS  digit anodes, active-low
//  DISPOUT    out  8           cathodes, active-low; [7]=DP, [6:0]=g..a
// BEHAVIOUR
//  Registers (reset value): 0x00 EN[N-1:0] (0); 0x04 DP[N-1:0] (0); 0x08 RAW[N-1:0] (0, 1=raw segs);
//   0x0C BLINK[N-1:0] (0); 0x10 BRIGHT[PWM_BITS:0] (2^PWM_BITS); 0x40+4k DIGIT_k[7:0] (0), k<NUM_DIGITS.
//  Writes: address phase with HSEL&HWRITE&HTRANS[1] latches HADDR; HWDATA committed at end of next cycle.
//  Reads: same latch with HWRITE=0; HRDATA = register zero-extended in data phase (zero wait states).
//  Unmapped or k>=NUM_DIGITS addresses: writes ignored, reads 0. Back-to-back transfers fully supported.
//  Scan: slot counter 0..REFRESH_DIV-1; at wrap digit index idx increments, NUM_DIGITS-1 wraps to 0.
//  Ghost blank: first cycle of every slot drives DISPENOUT all ones; cathodes update that same cycle.
//  Anode idx low iff EN[idx] & ~(BLINK[idx]&blink_ph) & (pwm_cnt < BRIGHT) & not blank cycle.
//  pwm_cnt: PWM_BITS free-running, wraps; BRIGHT=0 always off, BRIGHT>=2^PWM_BITS always on.
//  blink_ph toggles every BLINK_DIV cycles, reset 0 (digits visible first).
//  Cathodes: RAW[idx]=0 -> hex decode of DIGIT_idx[3:0] (0-F standard glyphs);
//   RAW[idx]=1 -> DIGIT_idx[6:0] active-high segs, inverted to pins. DP pin = ~DP[idx].
//  Disabled digits still consume their slot (uniform brightness).
//  DISPENOUT/DISPOUT are registered: 1-cycle latency from idx/state to pins. Reset: both all ones.
//  Register write landing on a slot boundary: new value visible from next cycle's output register load.
//  HRESET mid-scan: all counters, idx, blink_ph, registers to reset values next edge; pins blank.
// STRUCTURE
//  mfp_ahb_const.vh: register offsets (SEG_EN/DP/RAW/BLINK/BRIGHT/DIGIT_BASE) and hex glyph table.
//  Sub-module mfp_ahb_sevensegscan: slot/idx counters, pwm_cnt, blink_ph, blank flag; top keeps regs, decode, pins.
// TESTING
//  Reset, EN=0xFF, DIGIT0=4'h3 -> slot 0: DISPENOUT=8'hFE, DISPOUT=8'hB0 after blank cycle; first slot cycle anodes 8'hFF.
//  REFRESH_DIV=4, NUM_DIGITS=3: idx sequence 0,1,2,0 every 4 cycles; DISPENOUT[7:3] never driven (width 3).
//  RAW[1]=1, DIGIT1=8'h49, DP[1]=1 -> slot 1 DISPOUT=8'h36; write 0x5C readback = 0.
//  BRIGHT=4, PWM_BITS=4 -> anode low exactly 4 of 16 cycles in steady slot; BRIGHT=0 -> never low; BRIGHT=16 -> always low.
//  BLINK[0]=1, BLINK_DIV=8 -> digit0 on 8 cycles, off 8 cycles; other digits unaffected.
//  Back-to-back write 0x40<=5 then read 0x40 -> HRDATA=32'h5 in read data phase; HRESET mid-scan -> pins 8'hFF, idx=0.

Source files
------------

// File: rtl/mfp_ahb_sevenseg_multi_pkg.sv
// Shared constants for the multi-digit seven-segment AHB slave.
//   - Register word offsets (byte address >> 2) for the control registers
//     and the base of the per-digit value registers.
//   - hex_glyph(): 4-bit value to active-high segment pattern {g,f,e,d,c,b,a}.
package mfp_ahb_sevenseg_multi_pkg;

  // Word offsets; the bus decodes HADDR[7:2] against these.
  localparam logic [5:0] SEG_EN_W         = 6'h00;  // byte 0x00
  localparam logic [5:0] SEG_DP_W         = 6'h01;  // byte 0x04
  localparam logic [5:0] SEG_RAW_W        = 6'h02;  // byte 0x08
  localparam logic [5:0] SEG_BLINK_W      = 6'h03;  // byte 0x0C
  localparam logic [5:0] SEG_BRIGHT_W     = 6'h04;  // byte 0x10
  localparam logic [5:0] SEG_DIGIT_BASE_W = 6'h10;  // byte 0x40, one word per digit

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mfp_ahb_sevenseg_multi_scan.sv
// Scan timing for the multiplexed display.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   idx_o      : digit currently owning the display slot
//   blank_o    : high on the first cycle of every slot (ghost suppression)
//   pwm_cnt_o  : free-running brightness counter
//   blink_ph_o : blink phase, 0 = blinking digits visible
module mfp_ahb_sevenseg_multi_scan #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 25000,
  parameter int BLINK_DIV   = 12500000,
  parameter int PWM_BITS    = 4,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic [IDX_W-1:0]    idx_o,
  output logic                blank_o,
  output logic [PWM_BITS-1:0] pwm_cnt_o,
  output logic                blink_ph_o
);

  localparam int SLOT_W  = $clog2(REFRESH_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_ph_q, blink_ph_d;

  always_comb begin
    slot_d      = slot_q + SLOT_W'(1);
    idx_d       = idx_q;
    pwm_d       = pwm_q + PWM_BITS'(1);
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_ph_d  = blink_ph_q;
    if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q      <= '0;
      idx_q       <= '0;
      pwm_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      pwm_q       <= pwm_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  assign idx_o      = idx_q;
  assign blank_o    = (slot_q == '0);
  assign pwm_cnt_o  = pwm_q;
  assign blink_ph_o = blink_ph_q;

endmodule

// File: rtl/mfp_ahb_sevenseg_multi.sv
// AHB-Lite slave driving an N-digit multiplexed seven-segment display.
//   HCLK/HRESET : clock, synchronous active-high reset
//   HADDR, HWDATA, HWRITE, HSEL, HTRANS : AHB-Lite slave inputs (HREADY assumed high)
//   HRDATA      : read data, valid in the read data phase, zero otherwise
//   DISPENOUT   : digit anodes, active-low, registered
//   DISPOUT     : cathodes {DP,g..a}, active-low, registered
//
// Transfer handshake: a transfer is accepted in any cycle where
// HSEL & HTRANS[1] is high (the slave is always ready, zero wait states).
// The accepted word address is held for one cycle; a write commits HWDATA
// at the end of that data-phase cycle, a read presents the register on
// HRDATA during it. Back-to-back transfers overlap address and data phases.
module mfp_ahb_sevenseg_multi
  import mfp_ahb_sevenseg_multi_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 25000,
  parameter int BLINK_DIV   = 12500000,
  parameter int PWM_BITS    = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [7:0]            HADDR,
  input  logic [31:0]           HWDATA,
  input  logic                  HWRITE,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  output logic [31:0]           HRDATA,
  output logic [NUM_DIGITS-1:0] DISPENOUT,
  output logic [7:0]            DISPOUT
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PWM_BITS:0] BRIGHT_RST = {1'b1, {PWM_BITS{1'b0}}};

  // Bus phase tracking and registers
  logic                  wr_pend_q, rd_pend_q;
  logic [5:0]            addr_q;
  logic [NUM_DIGITS-1:0] en_q, dp_q, raw_q, blink_q;
  logic [PWM_BITS:0]     bright_q;
  logic [7:0]            digit_q [NUM_DIGITS];

  logic [5:0]  digit_k;
  logic        digit_hit;
  logic [31:0] rdata;

  // Scan state
  logic [IDX_W-1:0]    idx;
  logic                blank;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                blink_ph;

  // Pin staging
  logic [7:0]            cur_digit;
  logic                  cur_en, cur_dp, cur_raw, cur_blink, lit;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] anode_d, anode_q;
  logic [7:0]            cath_d, cath_q;

  logic unused_bits;
  assign unused_bits = ^{HADDR[1:0], HWDATA, HTRANS[0], cur_digit[7]};

  mfp_ahb_sevenseg_multi_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .BLINK_DIV  (BLINK_DIV),
    .PWM_BITS   (PWM_BITS)
  ) u_scan (
    .clk_i     (HCLK),
    .rst_i     (HRESET),
    .idx_o     (idx),
    .blank_o   (blank),
    .pwm_cnt_o (pwm_cnt),
    .blink_ph_o(blink_ph)
  );

  // Digit registers live in a window above the control block; words past
  // the last implemented digit decode to nothing.
  assign digit_k   = addr_q - SEG_DIGIT_BASE_W;
  assign digit_hit = (addr_q >= SEG_DIGIT_BASE_W) && (digit_k < 6'(NUM_DIGITS));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      addr_q    <= '0;
      en_q      <= '0;
      dp_q      <= '0;
      raw_q     <= '0;
      blink_q   <= '0;
      bright_q  <= BRIGHT_RST;
    end else begin
      wr_pend_q <= HSEL & HTRANS[1] & HWRITE;
      rd_pend_q <= HSEL & HTRANS[1] & ~HWRITE;
      addr_q    <= HADDR[7:2];
      if (wr_pend_q) begin
        case (addr_q)
          SEG_EN_W:     en_q     <= HWDATA[NUM_DIGITS-1:0];
          SEG_DP_W:     dp_q     <= HWDATA[NUM_DIGITS-1:0];
          SEG_RAW_W:    raw_q    <= HWDATA[NUM_DIGITS-1:0];
          SEG_BLINK_W:  blink_q  <= HWDATA[NUM_DIGITS-1:0];
          SEG_BRIGHT_W: bright_q <= HWDATA[PWM_BITS:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge HCLK) begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (HRESET) begin
        digit_q[k] <= '0;
      end else if (wr_pend_q && digit_hit && (digit_k == 6'(k))) begin
        digit_q[k] <= HWDATA[7:0];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr_q)
      SEG_EN_W:     rdata = 32'(en_q);
      SEG_DP_W:     rdata = 32'(dp_q);
      SEG_RAW_W:    rdata = 32'(raw_q);
      SEG_BLINK_W:  rdata = 32'(blink_q);
      SEG_BRIGHT_W: rdata = 32'(bright_q);
      default: begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (digit_hit && (digit_k == 6'(k))) rdata = {24'b0, digit_q[k]};
        end
      end
    endcase
  end

  assign HRDATA = rd_pend_q ? rdata : '0;

  // Pick the settings of the digit owning this slot, then form pin values.
  // bright_q is one bit wider than the PWM counter so full scale means
  // always on and zero means always off.
  always_comb begin
    cur_digit = '0;
    cur_en    = 1'b0;
    cur_dp    = 1'b0;
    cur_raw   = 1'b0;
    cur_blink = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_digit = digit_q[k];
        cur_en    = en_q[k];
        cur_dp    = dp_q[k];
        cur_raw   = raw_q[k];
        cur_blink = blink_q[k];
      end
    end
    lit = cur_en & ~(cur_blink & blink_ph) & ({1'b0, pwm_cnt} < bright_q) & ~blank;
    seg = cur_raw ? cur_digit[6:0] : hex_glyph(cur_digit[3:0]);
    anode_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((idx == IDX_W'(k)) && lit) anode_d[k] = 1'b0;
    end
    cath_d = {~cur_dp, ~seg};
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      anode_q <= '1;
      cath_q  <= '1;
    end else begin
      anode_q <= anode_d;
      cath_q  <= cath_d;
    end
  end

  assign DISPENOUT = anode_q;
  assign DISPOUT   = cath_q;

endmodule

// File: tb/tb_mfp_ahb_sevenseg_multi.sv
// Bench for mfp_ahb_sevenseg_multi. Two instances share one AHB bus:
//   u_dut  : 8 digits, 32-cycle slots, blink half-period 8
//   u_scan : 3 digits, 4-cycle slots, blink half-period 8
// cnt counts clock edges since reset release; after the edge where
// cnt == n, the pins reflect scan count n-1. For u_dut at count c:
// slot = c%32, digit = (c/32)%8, pwm = c%16, blink phase = (c/8)%2.
module tb_mfp_ahb_sevenseg_multi;

  // ---------------- clock / reset ----------------
  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HRESET;
  logic [7:0]  HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic [31:0] hrdata_a, hrdata_s;
  logic [7:0]  dispen_a, dispout_a, dispout_s;
  logic [2:0]  dispen_s;

  mfp_ahb_sevenseg_multi #(
    .NUM_DIGITS(8), .REFRESH_DIV(32), .BLINK_DIV(8), .PWM_BITS(4)
  ) u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSEL(HSEL), .HTRANS(HTRANS), .HRDATA(hrdata_a),
    .DISPENOUT(dispen_a), .DISPOUT(dispout_a)
  );

  mfp_ahb_sevenseg_multi #(
    .NUM_DIGITS(3), .REFRESH_DIV(4), .BLINK_DIV(8), .PWM_BITS(4)
  ) u_scan (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSEL(HSEL), .HTRANS(HTRANS), .HRDATA(hrdata_s),
    .DISPENOUT(dispen_s), .DISPOUT(dispout_s)
  );

  int cnt;
  always @(posedge HCLK) begin
    if (HRESET) cnt <= 0;
    else        cnt <= cnt + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t cnt=%0d)", name, act, exp, $time, cnt);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Bit 32 selects the instance whose HRDATA is checked (1 = u_scan).
  logic [32:0] exp_q[$];
  logic [32:0] e;
  logic        rd_dph = 1'b0;

  always @(posedge HCLK) rd_dph <= !HRESET && HSEL && HTRANS[1] && !HWRITE;

  always @(negedge HCLK) begin
    if (rd_dph) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_read: got %h, expected no read", hrdata_a);
      end else begin
        e = exp_q.pop_front();
        check(e[32] ? "hrdata_scan" : "hrdata_dut", e[32] ? hrdata_s : hrdata_a, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(negedge HCLK);
    bus_idle();
    HWDATA = d;
  endtask

  task automatic ahb_read(input logic [7:0] a, input logic unit, input logic [31:0] exp);
    exp_q.push_back({unit, exp});
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(negedge HCLK);
    bus_idle();
  endtask

  task automatic wait_cnt(input int t);
    int g = 0;
    while (cnt < t && g < 5000) begin
      @(negedge HCLK);
      g++;
    end
    check("schedule_cnt", 32'(cnt), 32'(t));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int         lows;
  int         c;
  logic [2:0] ex3;

  initial begin
    HRESET = 1'b1; HADDR = '0; HWDATA = '0;
    bus_idle();
    repeat (3) @(negedge HCLK);
    check("rst_dispen_dut", 32'(dispen_a), 32'hFF);
    check("rst_dispout_dut", 32'(dispout_a), 32'hFF);
    check("rst_dispen_scan", 32'(dispen_s), 32'h7);
    HRESET = 1'b0;

    // Register setup and readback
    ahb_read(8'h10, 1'b0, 32'h10);          // BRIGHT reset value
    ahb_write(8'h00, 32'hFFFF_FFFF);        // EN, truncated to digit count
    ahb_write(8'h40, 32'h0000_0003);        // DIGIT0 = 3
    ahb_write(8'h08, 32'h0000_0002);        // RAW[1]
    ahb_write(8'h44, 32'h0000_0049);        // DIGIT1 raw segments
    ahb_write(8'h04, 32'h0000_0002);        // DP[1]
    ahb_write(8'h5C, 32'h0000_00AB);        // DIGIT7: real on u_dut, absent on u_scan
    ahb_write(8'h20, 32'hDEAD_BEEF);        // unmapped
    ahb_read(8'h00, 1'b0, 32'hFF);
    ahb_read(8'h00, 1'b1, 32'h7);
    ahb_read(8'h40, 1'b0, 32'h3);
    ahb_read(8'h44, 1'b0, 32'h49);
    ahb_read(8'h08, 1'b0, 32'h2);
    ahb_read(8'h04, 1'b0, 32'h2);
    ahb_read(8'h5C, 1'b0, 32'hAB);
    ahb_read(8'h5C, 1'b1, 32'h0);
    ahb_read(8'h20, 1'b0, 32'h0);

    // Digit 0, second scan: blank cycle then lit with glyph 3
    wait_cnt(257);
    check("slot0_blank_dispen", 32'(dispen_a), 32'hFF);
    check("slot0_blank_dispout", 32'(dispout_a), 32'hB0);
    @(negedge HCLK);
    check("slot0_dispen", 32'(dispen_a), 32'hFE);
    check("slot0_dispout", 32'(dispout_a), 32'hB0);

    // Small instance: digit index steps 0,1,2,0 every 4 cycles, blank first
    wait_cnt(260);
    for (int i = 0; i < 24; i++) begin
      c = 259 + i;
      ex3 = 3'b111;
      if (c % 4 != 0) ex3[(c / 4) % 3] = 1'b0;
      check($sformatf("scan3_c%0d", c), 32'(dispen_s), 32'(ex3));
      @(negedge HCLK);
    end

    // Digit 1 in raw mode with decimal point
    wait_cnt(290);
    check("slot1_dispen", 32'(dispen_a), 32'hFD);
    check("slot1_raw_dispout", 32'(dispout_a), 32'h36);

    // Blink digit 0: hidden for counts 520..527, shown for 528..535
    ahb_write(8'h0C, 32'h1);
    wait_cnt(521);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("blink_d0_c%0d", 520 + i), 32'(dispen_a), (i < 8) ? 32'hFF : 32'hFE);
      @(negedge HCLK);
    end
    // Digit 1 unaffected across both blink phases
    wait_cnt(546);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("blink_d1_c%0d", 545 + i), 32'(dispen_a), 32'hFD);
      @(negedge HCLK);
    end

    // Brightness 4/16 (upper write bits dropped)
    ahb_write(8'h0C, 32'h0);
    ahb_write(8'h10, 32'hFFFF_FF04);
    ahb_read(8'h10, 1'b0, 32'h4);
    wait_cnt(785);
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      if (dispen_a[0] == 1'b0) lows++;
      @(negedge HCLK);
    end
    check("bright4_low_cycles", 32'(lows), 32'd4);

    // Brightness 0: never lit
    ahb_write(8'h10, 32'h0);
    wait_cnt(1041);
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      if (dispen_a[0] == 1'b0) lows++;
      @(negedge HCLK);
    end
    check("bright0_low_cycles", 32'(lows), 32'd0);

    // Brightness full scale: always lit
    ahb_write(8'h10, 32'h10);
    wait_cnt(1297);
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      if (dispen_a[0] == 1'b0) lows++;
      @(negedge HCLK);
    end
    check("bright16_low_cycles", 32'(lows), 32'd16);

    // Back-to-back write then read of DIGIT0
    exp_q.push_back({1'b0, 32'h5});
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 8'h40;
    @(negedge HCLK);
    HWRITE = 1'b0; HADDR = 8'h40; HWDATA = 32'h5;
    @(negedge HCLK);
    bus_idle();
    ahb_read(8'h40, 1'b1, 32'h5);

    // Reset in the middle of a scan
    @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    check("midrst_dispen_dut", 32'(dispen_a), 32'hFF);
    check("midrst_dispout_dut", 32'(dispout_a), 32'hFF);
    check("midrst_dispen_scan", 32'(dispen_s), 32'h7);
    HRESET = 1'b0;
    ahb_write(8'h00, 32'hFF);
    ahb_read(8'h40, 1'b0, 32'h0);
    ahb_read(8'h0C, 1'b0, 32'h0);
    // Count 9: u_dut digit 0 mid-slot showing reset glyph 0; u_scan digit 2
    wait_cnt(10);
    check("post_rst_dispen_dut", 32'(dispen_a), 32'hFE);
    check("post_rst_dispout_dut", 32'(dispout_a), 32'hC0);
    check("post_rst_dispen_scan", 32'(dispen_s), 32'h3);

    repeat (3) @(negedge HCLK);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
